// File: rtl/ballot_controller.sv
// Per-voter session sequencer: arms one ballot per officer release, accepts a
// single clean candidate press, emits a one-cycle cast pulse and counts voters.
module ballot_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ballot_en,
  input  logic             i_BJP,
  input  logic             i_INC,
  input  logic             i_JDS,
  input  logic             i_voting_over,
  output logic             o_cast_BJP,
  output logic             o_cast_INC,
  output logic             o_cast_JDS,
  output logic             o_armed,
  output logic             o_reject,
  output logic             o_timeout,
  output logic             o_closed,
  output logic [CNT_W-1:0] o_voters
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAST,
    RELEASE,
    CLOSED
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    buttons;
  logic [2:0]    prev;
  logic [2:0]    edges;
  logic [2:0]    held_before;
  logic          press_valid;
  logic          press_invalid;

  // Bit order everywhere is {JDS, INC, BJP}.
  assign buttons       = {i_JDS, i_INC, i_BJP};
  assign edges         = buttons & ~prev;
  assign held_before   = buttons & prev;
  assign press_valid   = $onehot(edges) && (held_before == 3'b000);
  assign press_invalid = (edges != 3'b000) && !press_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      prev       <= 3'b000;
      o_cast_BJP <= 1'b0;
      o_cast_INC <= 1'b0;
      o_cast_JDS <= 1'b0;
      o_armed    <= 1'b0;
      o_reject   <= 1'b0;
      o_timeout  <= 1'b0;
      o_closed   <= 1'b0;
      o_voters   <= '0;
    end else begin
      prev       <= buttons;
      o_cast_BJP <= 1'b0;
      o_cast_INC <= 1'b0;
      o_cast_JDS <= 1'b0;
      o_reject   <= 1'b0;
      o_timeout  <= 1'b0;
      // Close of poll overrides everything, including a press in the same cycle.
      if (i_voting_over || state == CLOSED) begin
        state    <= CLOSED;
        o_closed <= 1'b1;
        o_armed  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_ballot_en) begin
              state   <= ARMED;
              o_armed <= 1'b1;
              timer   <= '0;
            end
          end
          ARMED: begin
            if (press_valid) begin
              state   <= CAST;
              o_armed <= 1'b0;
              {o_cast_JDS, o_cast_INC, o_cast_BJP} <= edges;
              if (o_voters != {CNT_W{1'b1}}) begin
                o_voters <= o_voters + CNT_W'(1);
              end
            end else begin
              if (press_invalid) begin
                o_reject <= 1'b1;
              end
              if (timer == TIMER_LAST) begin
                state     <= IDLE;
                o_armed   <= 1'b0;
                o_timeout <= 1'b1;
              end else begin
                timer <= timer + TW'(1);
              end
            end
          end
          CAST: begin
            state <= RELEASE;
          end
          RELEASE: begin
            if (buttons == 3'b000) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
